lsq_writeback: RTL and testbench
================================

LSQ_WRITEBACK -- requirements
Module: lsq_writeback

Interface
REQ-001 Parameters (name, default, meaning), each SHALL be honoured:
- DATA_WIDTH, 16, lane data width.
- ADDR_WIDTH, 8, data-memory address width.
- FIFO_DEPTH, 4, completion-buffer entries (power of 2).
REQ-002 Ports (name, direction, width, meaning), in order; there SHALL be one clock, and reset SHALL be asynchronous and active-low:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-low reset.
- done_bit_q, in, 1, one-cycle completion pulse from the load/store queue; no backpressure.
- instr_bit_out_q, in, 1, 0 = load, 1 = store.
- warp_num_out_q, in, 2, warp id.
- dest_reg_out_q, in, 4, destination register (loads).
- addr_out_q, in, ADDR_WIDTH x8, per-lane address.
- thread_mask_q, in, 8, per-lane active mask.
- reg_data_q, in, DATA_WIDTH x8, per-lane store data.
- mem_addr, out, ADDR_WIDTH, data-memory address.
- mem_rd_en, out, 1, memory read strobe; data returns on mem_rd_data the next cycle.
- mem_wr_en, out, 1, memory write strobe.
- mem_wr_data, out, DATA_WIDTH, memory write data.
- mem_rd_data, in, DATA_WIDTH, memory read data.
- rf_wr_en, out, 1, register-file write strobe.
- rf_warp, out, 2, register-file warp.
- rf_reg, out, 4, register-file register.
- rf_lane, out, 3, register-file lane.
- rf_wr_data, out, DATA_WIDTH, register-file write data.
- wb_done, out, 1, one-cycle pulse when an entry retires.
- wb_warp, out, 2, warp of the retired entry.
- fifo_full, out, 1, buffer full.
- busy, out, 1, FSM not IDLE.
- overflow, out, 1, sticky flag: a completion was dropped.

Function
REQ-003 Completion buffer: FIFO of FIFO_DEPTH entries {instr, warp, dest, addr[8], mask, data[8]}. It SHALL be captured on any clk edge where done_bit_q=1 and the buffer is not full.
REQ-004 Pointers SHALL wrap modulo FIFO_DEPTH. A count of width clog2(FIFO_DEPTH)+1 SHALL be kept. fifo_full SHALL be 1 when count = FIFO_DEPTH.
REQ-005 Push while full with a pop in the same cycle SHALL be accepted. Push while full with no pop SHALL drop the entry and set overflow, which SHALL clear only on reset.
REQ-006 FSM states SHALL be IDLE, ACCESS, DRAIN, DONE.
- IDLE: if count>0, pop the head into the working register, set lane=0, go to ACCESS; otherwise stay in IDLE.
- ACCESS: one lane per cycle, lanes 0..7 in order; after lane 7, go to DRAIN.
- DRAIN: one cycle, then go to DONE.
- DONE: one cycle with wb_done=1 and wb_warp=entry warp, then go to IDLE.
REQ-007 ACCESS with an active lane that is a load: in that cycle, mem_rd_en=1 and mem_addr=addr[lane]. In the next cycle (ACCESS or DRAIN), rf_wr_en=1, rf_warp=warp, rf_reg=dest, rf_lane=previous lane, and rf_wr_data=mem_rd_data.
REQ-008 ACCESS with an active lane that is a store: mem_wr_en=1, mem_addr=addr[lane], mem_wr_data=data[lane]; rf_wr_en SHALL never assert for a store.
REQ-009 A masked-off lane SHALL still consume its ACCESS cycle with all strobes 0. An all-zero mask SHALL still run the full sequence and pulse wb_done.
REQ-010 Timing: done_bit_q high in cycle 0 with the FSM idle and the buffer empty SHALL give IDLE pop in cycle 1, ACCESS in cycles 2-9, DRAIN in 10, and wb_done in 11. Each entry SHALL take exactly 11 cycles of service.
REQ-011 mem_rd_en and mem_wr_en SHALL be mutually exclusive. At most one strobe of each kind per cycle. Strobes SHALL be 0 outside ACCESS, except the REQ-007 register-file write in DRAIN.
REQ-012 busy SHALL equal (state != IDLE). Every output SHALL be driven from registers.

Reset
REQ-013 reset=0 SHALL immediately force:
- all outputs to 0;
- state to IDLE;
- pointers, count and overflow to 0.
REQ-014 Reset mid-operation SHALL abandon the working entry and buffered entries. No wb_done or rf write for abandoned entries SHALL occur after reset deasserts.
REQ-015 After reset deasserts, the first done_bit_q SHALL be serviced per REQ-010.

Verification
REQ-016 Single load: warp 2, dest 5, mask 8'hFF, addr[i]=i+16, memory returns addr+100. Required response:
- mem_rd_en cycles 2-9;
- rf writes in cycles 3-10, lane i data i+116;
- wb_done=1, wb_warp=2 in cycle 11.
REQ-017 Store: mask 8'hA5, data[i]=i*3. Required response:
- mem_wr_en only for lanes 0, 2, 5, 7, with mem_wr_data 0, 6, 15, 21;
- rf_wr_en never asserts;
- wb_done in cycle 11.
REQ-018 Burst: six done pulses on consecutive cycles with the FSM idle. Required response:
- entries 1-5 accepted (one popped in cycle 1 frees a slot);
- the sixth is dropped and overflow=1;
- five wb_done pulses, 11 cycles apart, in arrival order.
REQ-019 Mask 8'h00 load: no memory or register-file strobes, and wb_done in cycle 11.
REQ-020 Reset asserted in cycle 6 of a load, with two entries buffered: outputs go to 0 that cycle. After release, no wb_done occurs until a new done pulse, which completes 11 cycles later.

Source files
------------

// File: rtl/lsq_writeback.sv
// Load/store queue writeback: buffers completion pulses and serialises each entry
// into eight per-lane memory accesses, forwarding load data to the register file.
module lsq_writeback #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    done_bit_q,
  input  logic                    instr_bit_out_q,
  input  logic [1:0]              warp_num_out_q,
  input  logic [3:0]              dest_reg_out_q,
  input  logic [8*ADDR_WIDTH-1:0] addr_out_q,
  input  logic [7:0]              thread_mask_q,
  input  logic [8*DATA_WIDTH-1:0] reg_data_q,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_rd_en,
  output logic                    mem_wr_en,
  output logic [DATA_WIDTH-1:0]   mem_wr_data,
  input  logic [DATA_WIDTH-1:0]   mem_rd_data,
  output logic                    rf_wr_en,
  output logic [1:0]              rf_warp,
  output logic [3:0]              rf_reg,
  output logic [2:0]              rf_lane,
  output logic [DATA_WIDTH-1:0]   rf_wr_data,
  output logic                    wb_done,
  output logic [1:0]              wb_warp,
  output logic                    fifo_full,
  output logic                    busy,
  output logic                    overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, DONE} state_t;

  state_t state_reg, state_next;
  logic [2:0] lane_reg, lane_next;

  logic                    fifo_instr [FIFO_DEPTH];
  logic [1:0]              fifo_warp  [FIFO_DEPTH];
  logic [3:0]              fifo_dest  [FIFO_DEPTH];
  logic [8*ADDR_WIDTH-1:0] fifo_addr  [FIFO_DEPTH];
  logic [7:0]              fifo_mask  [FIFO_DEPTH];
  logic [8*DATA_WIDTH-1:0] fifo_data  [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic             push, pop, full_now;

  logic                    cur_instr_reg, cur_instr_next;
  logic [1:0]              cur_warp_reg, cur_warp_next;
  logic [3:0]              cur_dest_reg, cur_dest_next;
  logic [8*ADDR_WIDTH-1:0] cur_addr_reg, cur_addr_next;
  logic [7:0]              cur_mask_reg, cur_mask_next;
  logic [8*DATA_WIDTH-1:0] cur_data_reg, cur_data_next;

  logic [ADDR_WIDTH-1:0] addr_lane [8];
  logic [DATA_WIDTH-1:0] data_lane [8];
  logic                  lane_active;

  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic                  mem_rd_en_reg, mem_rd_en_next;
  logic                  mem_wr_en_reg, mem_wr_en_next;
  logic [DATA_WIDTH-1:0] mem_wr_data_reg, mem_wr_data_next;
  logic                  rf_wr_en_reg, rf_wr_en_next;
  logic [1:0]            rf_warp_reg, rf_warp_next;
  logic [3:0]            rf_reg_reg, rf_reg_next;
  logic [2:0]            rf_lane_reg, rf_lane_next;
  logic                  wb_done_reg, wb_done_next;
  logic [1:0]            wb_warp_reg, wb_warp_next;
  logic                  fifo_full_reg, busy_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A full buffer still accepts a push when the head leaves in the same cycle.
  always_comb begin
    full_now      = (count_reg == CNT_W'(FIFO_DEPTH));
    pop           = (state_reg == IDLE) && (count_reg != '0);
    push          = done_bit_q && (!full_now || pop);
    wr_ptr_next   = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next   = pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    count_next    = count_reg + CNT_W'(push) - CNT_W'(pop);
    overflow_next = overflow_reg | (done_bit_q && full_now && !pop);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr_reg] <= instr_bit_out_q;
      fifo_warp[wr_ptr_reg]  <= warp_num_out_q;
      fifo_dest[wr_ptr_reg]  <= dest_reg_out_q;
      fifo_addr[wr_ptr_reg]  <= addr_out_q;
      fifo_mask[wr_ptr_reg]  <= thread_mask_q;
      fifo_data[wr_ptr_reg]  <= reg_data_q;
    end
  end

  always_comb begin
    cur_instr_next = cur_instr_reg;
    cur_warp_next  = cur_warp_reg;
    cur_dest_next  = cur_dest_reg;
    cur_addr_next  = cur_addr_reg;
    cur_mask_next  = cur_mask_reg;
    cur_data_next  = cur_data_reg;
    if (pop) begin
      cur_instr_next = fifo_instr[rd_ptr_reg];
      cur_warp_next  = fifo_warp[rd_ptr_reg];
      cur_dest_next  = fifo_dest[rd_ptr_reg];
      cur_addr_next  = fifo_addr[rd_ptr_reg];
      cur_mask_next  = fifo_mask[rd_ptr_reg];
      cur_data_next  = fifo_data[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      lane_reg     <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lane_reg     <= lane_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    lane_next  = lane_reg;
    case (state_reg)
      IDLE: begin
        if (pop) begin
          state_next = ACCESS;
          lane_next  = 3'd0;
        end
      end
      ACCESS: begin
        if (lane_reg == 3'd7) state_next = DRAIN;
        else                  lane_next  = lane_reg + 3'd1;
      end
      DRAIN:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      assign addr_lane[gi] = cur_addr_next[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign data_lane[gi] = cur_data_next[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Outputs are computed for the upcoming state so they land in the cycle that state is held.
  always_comb begin
    lane_active      = (state_next == ACCESS) && cur_mask_next[lane_next];
    mem_rd_en_next   = lane_active && !cur_instr_next;
    mem_wr_en_next   = lane_active && cur_instr_next;
    mem_addr_next    = lane_active ? addr_lane[lane_next] : '0;
    mem_wr_data_next = mem_wr_en_next ? data_lane[lane_next] : '0;
    rf_wr_en_next    = mem_rd_en_reg;
    rf_warp_next     = mem_rd_en_reg ? cur_warp_reg : '0;
    rf_reg_next      = mem_rd_en_reg ? cur_dest_reg : '0;
    rf_lane_next     = mem_rd_en_reg ? lane_reg : '0;
    wb_done_next     = (state_next == DONE);
    wb_warp_next     = wb_done_next ? cur_warp_reg : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_instr_reg   <= 1'b0;
      cur_warp_reg    <= '0;
      cur_dest_reg    <= '0;
      cur_addr_reg    <= '0;
      cur_mask_reg    <= '0;
      cur_data_reg    <= '0;
      mem_addr_reg    <= '0;
      mem_rd_en_reg   <= 1'b0;
      mem_wr_en_reg   <= 1'b0;
      mem_wr_data_reg <= '0;
      rf_wr_en_reg    <= 1'b0;
      rf_warp_reg     <= '0;
      rf_reg_reg      <= '0;
      rf_lane_reg     <= '0;
      wb_done_reg     <= 1'b0;
      wb_warp_reg     <= '0;
      fifo_full_reg   <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      cur_instr_reg   <= cur_instr_next;
      cur_warp_reg    <= cur_warp_next;
      cur_dest_reg    <= cur_dest_next;
      cur_addr_reg    <= cur_addr_next;
      cur_mask_reg    <= cur_mask_next;
      cur_data_reg    <= cur_data_next;
      mem_addr_reg    <= mem_addr_next;
      mem_rd_en_reg   <= mem_rd_en_next;
      mem_wr_en_reg   <= mem_wr_en_next;
      mem_wr_data_reg <= mem_wr_data_next;
      rf_wr_en_reg    <= rf_wr_en_next;
      rf_warp_reg     <= rf_warp_next;
      rf_reg_reg      <= rf_reg_next;
      rf_lane_reg     <= rf_lane_next;
      wb_done_reg     <= wb_done_next;
      wb_warp_reg     <= wb_warp_next;
      fifo_full_reg   <= (count_next == CNT_W'(FIFO_DEPTH));
      busy_reg        <= (state_next != IDLE);
    end
  end

  assign mem_addr    = mem_addr_reg;
  assign mem_rd_en   = mem_rd_en_reg;
  assign mem_wr_en   = mem_wr_en_reg;
  assign mem_wr_data = mem_wr_data_reg;
  assign rf_wr_en    = rf_wr_en_reg;
  assign rf_warp     = rf_warp_reg;
  assign rf_reg      = rf_reg_reg;
  assign rf_lane     = rf_lane_reg;
  // Read data arrives one cycle after the strobe; the registered enable qualifies it.
  assign rf_wr_data  = rf_wr_en_reg ? mem_rd_data : '0;
  assign wb_done     = wb_done_reg;
  assign wb_warp     = wb_warp_reg;
  assign fifo_full   = fifo_full_reg;
  assign busy        = busy_reg;
  assign overflow    = overflow_reg;

endmodule

// File: tb/tb_lsq_writeback.sv
// Randomised and directed bench for lsq_writeback against a timeline model of
// entry service (pop cycle s, lanes s+1..s+8, drain s+9, retire s+10).
module tb_lsq_writeback;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic               instr;
    logic [1:0]         warp;
    logic [3:0]         dest;
    logic [7:0][AW-1:0] addr;
    logic [7:0]         mask;
    logic [7:0][DW-1:0] data;
  } entry_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          done_bit_q = 1'b0;
  logic          instr_bit_out_q = 1'b0;
  logic [1:0]    warp_num_out_q = '0;
  logic [3:0]    dest_reg_out_q = '0;
  logic [8*AW-1:0] addr_out_q = '0;
  logic [7:0]    thread_mask_q = '0;
  logic [8*DW-1:0] reg_data_q = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en, mem_wr_en;
  logic [DW-1:0] mem_wr_data;
  logic [DW-1:0] mem_rd_data = '0;
  logic          rf_wr_en;
  logic [1:0]    rf_warp;
  logic [3:0]    rf_reg;
  logic [2:0]    rf_lane;
  logic [DW-1:0] rf_wr_data;
  logic          wb_done;
  logic [1:0]    wb_warp;
  logic          fifo_full, busy, overflow;

  always #5 clk = ~clk;

  lsq_writeback #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .done_bit_q(done_bit_q), .instr_bit_out_q(instr_bit_out_q),
    .warp_num_out_q(warp_num_out_q), .dest_reg_out_q(dest_reg_out_q), .addr_out_q(addr_out_q),
    .thread_mask_q(thread_mask_q), .reg_data_q(reg_data_q), .mem_addr(mem_addr),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data), .rf_wr_en(rf_wr_en), .rf_warp(rf_warp), .rf_reg(rf_reg),
    .rf_lane(rf_lane), .rf_wr_data(rf_wr_data), .wb_done(wb_done), .wb_warp(wb_warp),
    .fifo_full(fifo_full), .busy(busy), .overflow(overflow)
  );

  // Memory returns address + 100 one cycle after a read; a marker value otherwise.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? (16'(mem_addr) + 16'd100) : 16'hDEAD;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int wb_seen = 0;

  entry_t q[$];
  entry_t cur;
  bit     have_cur = 1'b0;
  int     cur_start = 0;
  bit     ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_outs"}, 32'({mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, rf_wr_en,
                               rf_warp, rf_reg, rf_lane}), 32'd0);
    check({tag, "_rfdata"}, 32'(rf_wr_data), 32'd0);
    check({tag, "_status"}, 32'({wb_done, wb_warp, fifo_full, busy, overflow}), 32'd0);
  endtask

  task automatic check_outputs();
    int k;
    int ln;
    logic          e_rd, e_wr, e_rf, e_done, e_busy;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;
    logic [1:0]    e_rfw, e_wbw;
    logic [3:0]    e_rfr;
    logic [2:0]    e_lane;
    e_rd = 0; e_wr = 0; e_rf = 0; e_done = 0;
    e_addr = '0; e_wdata = '0; e_rdata = '0; e_rfw = '0; e_wbw = '0; e_rfr = '0; e_lane = '0;
    k = have_cur ? cyc - cur_start : -1;
    if (k >= 1 && k <= 8) begin
      ln = k - 1;
      if (cur.mask[ln]) begin
        e_addr = cur.addr[ln];
        if (cur.instr) begin
          e_wr = 1;
          e_wdata = cur.data[ln];
        end else begin
          e_rd = 1;
        end
      end
    end
    if (k >= 2 && k <= 9) begin
      ln = k - 2;
      if (cur.mask[ln] && !cur.instr) begin
        e_rf = 1;
        e_rfw = cur.warp;
        e_rfr = cur.dest;
        e_lane = 3'(ln);
        e_rdata = 16'(cur.addr[ln]) + 16'd100;
      end
    end
    if (k == 10) begin
      e_done = 1;
      e_wbw = cur.warp;
      $display("cycle %0d: retire %s warp %0d dest %0d mask %02h", cyc,
               cur.instr ? "store" : "load", cur.warp, cur.dest, cur.mask);
    end
    e_busy = (k >= 1 && k <= 10);
    if (wb_done) wb_seen++;
    check("mem_rd_en", 32'(mem_rd_en), 32'(e_rd));
    check("mem_wr_en", 32'(mem_wr_en), 32'(e_wr));
    check("mem_addr", 32'(mem_addr), 32'(e_addr));
    check("mem_wr_data", 32'(mem_wr_data), 32'(e_wdata));
    check("rf_wr_en", 32'(rf_wr_en), 32'(e_rf));
    check("rf_target", 32'({rf_warp, rf_reg, rf_lane}), 32'({e_rfw, e_rfr, e_lane}));
    check("rf_wr_data", 32'(rf_wr_data), 32'(e_rdata));
    check("wb_done", 32'(wb_done), 32'(e_done));
    check("wb_warp", 32'(wb_warp), 32'(e_wbw));
    check("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
    check("busy", 32'(busy), 32'(e_busy));
    check("overflow", 32'(overflow), 32'(ovf));
  endtask

  // Called at a falling edge: check this cycle, drive this cycle's inputs, advance the model.
  task automatic step(input logic done, input entry_t e);
    int  k;
    int  sz;
    bit  pop;
    check_outputs();
    done_bit_q      = done;
    instr_bit_out_q = e.instr;
    warp_num_out_q  = e.warp;
    dest_reg_out_q  = e.dest;
    addr_out_q      = e.addr;
    thread_mask_q   = e.mask;
    reg_data_q      = e.data;
    k   = have_cur ? cyc - cur_start : 11;
    sz  = q.size();
    pop = (!have_cur || k >= 11) && sz > 0;
    if (pop) begin
      cur = q.pop_front();
      have_cur = 1'b1;
      cur_start = cyc;
    end
    if (done) begin
      if (sz < DEPTH || pop) q.push_back(e);
      else ovf = 1'b1;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    done_bit_q = 1'b0;
    #1;
    check_zero("async_rst");
    q.delete();
    have_cur = 1'b0;
    ovf = 1'b0;
    repeat (2) @(negedge clk);
    cyc += 2;
    check_zero("rst_hold");
    reset = 1'b1;
  endtask

  function automatic entry_t load_entry(input logic [1:0] w, input logic [3:0] d, input logic [7:0] m);
    entry_t e;
    e = '0;
    e.warp = w;
    e.dest = d;
    e.mask = m;
    for (int i = 0; i < 8; i++) e.addr[i] = 8'(i + 16 + 8 * d);
    return e;
  endfunction

  initial begin
    entry_t e;
    bit d;
    int base;
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    reset = 1'b1;
    idle(3);

    // Single load: warp 2, dest 5, addresses i+16.
    e = '0;
    e.warp = 2'd2; e.dest = 4'd5; e.mask = 8'hFF;
    for (int i = 0; i < 8; i++) e.addr[i] = 8'(i + 16);
    step(1'b1, e);
    idle(14);

    // Store on lanes 0,2,5,7 with data i*3.
    e = '0;
    e.instr = 1'b1; e.warp = 2'd1; e.dest = 4'd9; e.mask = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      e.addr[i] = 8'(i + 40);
      e.data[i] = 16'(i * 3);
    end
    step(1'b1, e);
    idle(14);

    // All-zero mask load still retires.
    step(1'b1, load_entry(2'd3, 4'd7, 8'h00));
    idle(14);

    // Six back-to-back pulses: five accepted, the sixth dropped.
    base = wb_seen;
    for (int i = 0; i < 6; i++) step(1'b1, load_entry(2'(i), 4'(i + 1), 8'(8'h11 << (i % 4))));
    idle(60);
    check("burst_retired", 32'(wb_seen - base), 32'd5);
    check("burst_overflow", 32'(overflow), 32'd1);

    // Reset in cycle 6 of a load with two more entries buffered.
    step(1'b1, load_entry(2'd1, 4'd2, 8'hFF));
    step(1'b1, load_entry(2'd2, 4'd3, 8'hFF));
    step(1'b1, load_entry(2'd3, 4'd4, 8'hFF));
    idle(3);
    do_reset();
    base = wb_seen;
    idle(20);
    check("post_reset_quiet", 32'(wb_seen - base), 32'd0);
    step(1'b1, load_entry(2'd0, 4'd6, 8'h3C));
    idle(14);

    // Fill the buffer, then push while full in the cycle the head is popped.
    for (int i = 0; i < 5; i++) step(1'b1, load_entry(2'(i), 4'(i + 8), 8'h81));
    idle(7);
    step(1'b1, load_entry(2'd2, 4'd15, 8'h7E));
    idle(70);
    check("full_pop_no_overflow", 32'(overflow), 32'd0);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      d = ($urandom_range(0, 5) == 0);
      e.instr = 1'($urandom_range(0, 1));
      e.warp  = 2'($urandom);
      e.dest  = 4'($urandom);
      e.mask  = 8'($urandom);
      for (int i = 0; i < 8; i++) begin
        e.addr[i] = 8'($urandom);
        e.data[i] = 16'($urandom);
      end
      step(d, e);
    end
    idle(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
